multisim_apb_arbiter: RTL and testbench
=======================================

Name: multisim_apb_arbiter

Overview:
- Shares one APB manager port among NUM_REQ APB requester ports. Typical requesters are several pull-side multisim APB servers, or servers plus local masters.
- Arbitration is round-robin. The granted requester holds the manager port for one full SETUP/ACCESS transfer.
- Responses are forwarded only to the granted requester.
- An optional timeout completes a hung transfer so the simulation cannot deadlock on a dead subordinate.

Parameters:
- NUM_REQ, 4: number of requester ports, 2..16.
- TIMEOUT_CYCLES, 64: maximum ACCESS cycles before a forced completion; 0 disables the timeout.
- apb_req_t, (none): packed APB request struct (paddr/pwrite/pwdata/pstrb/pprot), shared with the server blocks.
- apb_resp_t, (none): packed APB response struct (prdata/pslverr).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- i_apb_s_req  in  NUM_REQ x apb_req_t  per-requester request payload.
- i_apb_s_psel  in  NUM_REQ  per-requester psel.
- i_apb_s_penable  in  NUM_REQ  per-requester penable; protocol-checked only, not used for arbitration.
- o_apb_s_pready  out  NUM_REQ  per-requester pready; one-hot or zero.
- o_apb_s_resp  out  NUM_REQ x apb_resp_t  per-requester response; valid when the matching pready is 1, '0 otherwise.
- o_apb_m_req  out  apb_req_t  manager request payload.
- o_apb_m_psel  out  1  manager psel.
- o_apb_m_penable  out  1  manager penable.
- i_apb_m_pready  in  1  manager pready.
- i_apb_m_resp  in  apb_resp_t  manager response.
- o_grant  out  $clog2(NUM_REQ)  index of the current owner; 0 when idle.
- o_timeout  out  1  one-cycle pulse on a forced completion.

Behaviour:
- Reset:
  - clk and rst_n are decided: one clock; reset is synchronous and active-low.
  - Sampling rst_n=0 at a clk edge sets state=IDLE, rr_ptr=0, grant=0, timeout count=0.
  - All outputs read 0/'0 whenever state==IDLE and no completion is in progress, so they are 0 in the cycle after reset.
  - Reset mid-transfer abandons the transfer. No pready is sent and the manager psel drops after the reset edge.
- States (registered): IDLE, SETUP, ACCESS.
- Manager-side outputs:
  - o_apb_m_psel = (state != IDLE).
  - o_apb_m_penable = (state == ACCESS).
  - o_apb_m_req = i_apb_s_req[grant] when psel is high, else '0.
- IDLE:
  - If any i_apb_s_psel is set, pick the first set bit at or after rst_n-cleared rr_ptr, cyclic.
  - Latch that index as grant and go to SETUP.
  - Otherwise stay in IDLE.
- SETUP: go to ACCESS unconditionally; exactly 1 cycle.
- ACCESS with i_apb_m_pready=1 (completion):
  - o_apb_s_pready[grant]=1 and o_apb_s_resp[grant]=i_apb_m_resp, combinationally in the same cycle.
  - rr_ptr <= grant+1, wrapping at NUM_REQ-1 to 0.
  - Back-to-back: arbitrate among i_apb_s_psel with the grant bit masked, starting at grant+1. If any bit is set, go directly to SETUP with the new grant; else go to IDLE.
  - The completing requester is never re-granted in its own completion cycle.
- ACCESS with i_apb_m_pready=0:
  - Stay in ACCESS and increment the timeout count.
  - If TIMEOUT_CYCLES>0 and count==TIMEOUT_CYCLES-1, force completion: o_apb_s_pready[grant]=1, resp='0, o_timeout=1.
  - After a forced completion, go to IDLE (no back-to-back).
  - The count clears on every SETUP entry.
- Latency: a requester raising psel at cycle t in IDLE sees the manager SETUP at t+1 and ACCESS at t+2; earliest completion is t+2.
- Non-granted requesters see pready=0 and simply wait. They must hold psel and req stable, per APB.
- A granted requester dropping psel mid-transfer is a protocol violation. The transfer still completes with the latched grant, and an SVA assertion flags it (sim only).
- Simultaneous requests go in rr order. With all NUM_REQ asserting continuously, grants cycle 0,1,2,...,NUM_REQ-1,0.
- If i_apb_m_pready=1 in SETUP, it is ignored.

Decomposition:
- Package multisim_apb_arb_pkg: apb_arb_state_t enum (IDLE/SETUP/ACCESS, one-hot 3 bits) and the rr_next index helper function.
- Sub-module multisim_rr_arbiter:
  - Combinational masked round-robin picker.
  - Inputs: req vector, start pointer, mask. Outputs: found, index.
  - Used for both the IDLE pick and the back-to-back pick.

Test Plan (NUM_REQ=4, TIMEOUT_CYCLES=8):
1. Single transfer: psel[2]=1, paddr=0x40, manager pready=1 on first ACCESS. Expected: m_psel rises at t+1, penable at t+2; pready[2]=1 at t+2 with prdata=0xDEAD; grant=2; rr_ptr=3.
2. Contention: psel[0..3]=1 from t, pready always 1. Expected: grants 0,1,2,3,0 back-to-back with no IDLE cycles; exactly one pready per 2 cycles.
3. Wait states: pready low for 3 ACCESS cycles. Expected: penable high 4 cycles; requester pready only in cycle 4; req stable throughout.
4. Timeout: pready stuck low. Expected: after 8 ACCESS cycles, pready[grant]=1, resp='0, o_timeout=1 for 1 cycle; m_psel=0 next cycle; a fresh request is then served normally.
5. Reset mid-ACCESS: assert rst_n=0 for 1 cycle during ACCESS with psel[1]. Expected: no pready[1]; m_psel=0 after the edge; rr_ptr=0; the re-issued request is granted from index 0.
6. Fairness after idle: grant 3 completes, IDLE, then psel[0] and psel[3] rise together. Expected: grant 0 first, then 3.

Source files
------------

// File: rtl/multisim_apb_arb_pkg.sv
// multisim_apb_arb_pkg: shared types and index helper for the multisim APB arbiter
package multisim_apb_arb_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'b001,
    SETUP  = 3'b010,
    ACCESS = 3'b100
  } apb_arb_state_t;
  typedef struct packed {
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
  } multisim_apb_req_t;
  typedef struct packed {
    logic [31:0] prdata;
    logic        pslverr;
  } multisim_apb_resp_t;
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/multisim_rr_arbiter.sv
// multisim_rr_arbiter: combinational round-robin picker; mask bits are excluded from the pick
module multisim_rr_arbiter #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  input  logic [N-1:0]  mask,
  output logic          found,
  output logic [IW-1:0] idx
);
  logic [N-1:0]   elig;
  logic [2*N-1:0] rot;
  assign elig  = req & ~mask;
  assign rot   = {elig, elig} >> start;
  assign found = |elig;
  // descending scan so the lowest rotated offset wins
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (rot[i]) idx = IW'((int'(start) + i) % N);
  end
endmodule

// File: rtl/multisim_apb_arbiter.sv
// multisim_apb_arbiter: round-robin sharing of one APB manager port among NUM_REQ requesters,
// with an optional ACCESS timeout that force-completes a hung transfer
module multisim_apb_arbiter
  import multisim_apb_arb_pkg::*;
#(
  parameter int  NUM_REQ        = 4,
  parameter int  TIMEOUT_CYCLES = 64,
  parameter type apb_req_t      = multisim_apb_req_t,
  parameter type apb_resp_t     = multisim_apb_resp_t
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  apb_req_t  [NUM_REQ-1:0]    i_apb_s_req,
  input  logic      [NUM_REQ-1:0]    i_apb_s_psel,
  input  logic      [NUM_REQ-1:0]    i_apb_s_penable,
  output logic      [NUM_REQ-1:0]    o_apb_s_pready,
  output apb_resp_t [NUM_REQ-1:0]    o_apb_s_resp,
  output apb_req_t                   o_apb_m_req,
  output logic                       o_apb_m_psel,
  output logic                       o_apb_m_penable,
  input  logic                       i_apb_m_pready,
  input  apb_resp_t                  i_apb_m_resp,
  output logic [$clog2(NUM_REQ)-1:0] o_grant,
  output logic                       o_timeout
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  apb_arb_state_t state;
  logic [GW-1:0] grant, rr_ptr, start, pick;
  logic [NUM_REQ-1:0] mask;
  logic [CW-1:0] cnt;
  logic found, in_access, tmo, done;
  assign in_access = rst_n && state == ACCESS;
  assign tmo = in_access && !i_apb_m_pready && TIMEOUT_CYCLES > 0 && cnt == CW'(TIMEOUT_CYCLES - 1);
  assign done = in_access && (i_apb_m_pready || tmo);
  // in ACCESS the picker serves the back-to-back decision, excluding the current owner
  assign start = (state == ACCESS) ? GW'(rr_next(int'(grant), NUM_REQ)) : rr_ptr;
  assign mask = (state == ACCESS) ? NUM_REQ'(1) << grant : '0;
  multisim_rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req(i_apb_s_psel),
    .start(start),
    .mask(mask),
    .found(found),
    .idx(pick)
  );
  assign o_apb_m_psel = state != IDLE;
  assign o_apb_m_penable = state == ACCESS;
  assign o_apb_m_req = o_apb_m_psel ? i_apb_s_req[grant] : '0;
  assign o_grant = o_apb_m_psel ? grant : '0;
  assign o_timeout = tmo;
  always_comb begin
    o_apb_s_pready = '0;
    o_apb_s_resp = '0;
    o_apb_s_pready[grant] = done;
    o_apb_s_resp[grant] = (done && i_apb_m_pready) ? i_apb_m_resp : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant <= '0;
      cnt <= '0;
    end else begin
      unique case (state)
        IDLE: if (found) begin
          state <= SETUP;
          grant <= pick;
        end
        SETUP: begin
          state <= ACCESS;
          cnt <= '0;
        end
        ACCESS: if (i_apb_m_pready) begin
          rr_ptr <= start;
          state <= found ? SETUP : IDLE;
          if (found) grant <= pick;
        end else if (tmo) state <= IDLE;
        else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
`ifndef SYNTHESIS
  a_psel_held: assert property (@(posedge clk) disable iff (!rst_n) state != IDLE |-> i_apb_s_psel[grant]);
  a_penable: assert property (@(posedge clk) disable iff (!rst_n) state == ACCESS |-> i_apb_s_penable[grant]);
`endif
endmodule

// File: tb/tb_multisim_apb_arbiter.sv
// tb_multisim_apb_arbiter: directed scenarios plus random traffic, checked every cycle against
// a transaction-level model of ownership, rr pointer and completion rules
module tb_multisim_apb_arbiter;
  import multisim_apb_arb_pkg::*;
  localparam int N = 4;
  localparam int T = 8;
  typedef multisim_apb_req_t req_t;
  typedef multisim_apb_resp_t resp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  req_t [N-1:0] s_req = '0;
  logic [N-1:0] s_psel = '0;
  logic [N-1:0] s_pen = '0;
  logic [N-1:0] s_pready;
  resp_t [N-1:0] s_resp;
  req_t m_req;
  logic m_psel, m_pen, tmo;
  logic m_pready = 1'b0;
  resp_t m_resp = '0;
  logic [1:0] grant;
  int checks = 0, errors = 0, cyc = 0, c0 = 0, pen_cnt = 0;
  int own = -1, ptr = 0, cnt = 0, wl = 0;
  bit acc = 1'b0, stuck = 1'b0;
  logic [N-1:0] last_done = '0;
  int req_pct = 0, wait_max = 0, fixed_wait = -1, fix_data = -1;
  int g_q[$], c_q[$], t_q[$];

  always #5 clk = ~clk;

  multisim_apb_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .i_apb_s_req(s_req), .i_apb_s_psel(s_psel),
    .i_apb_s_penable(s_pen), .o_apb_s_pready(s_pready), .o_apb_s_resp(s_resp),
    .o_apb_m_req(m_req), .o_apb_m_psel(m_psel), .o_apb_m_penable(m_pen),
    .i_apb_m_pready(m_pready), .i_apb_m_resp(m_resp), .o_grant(grant), .o_timeout(tmo)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int start, input int excl);
    for (int k = 0; k < N; k++)
      if (v[(start + k) % N] && (start + k) % N != excl) return (start + k) % N;
    return -1;
  endfunction

  task automatic issue(input int i, input logic [31:0] addr);
    req_t r;
    r.paddr = addr;
    r.pwrite = 1'($urandom_range(1, 0));
    r.pwdata = $urandom();
    r.pstrb = 4'($urandom_range(15, 0));
    r.pprot = 3'($urandom_range(7, 0));
    s_req[i] = r;
    s_psel[i] = 1'b1;
    s_pen[i] = 1'b0;
  endtask

  task automatic advance();
    if (!rst_n) begin
      own = -1; acc = 1'b0; cnt = 0; ptr = 0;
    end else if (own < 0) own = pick(s_psel, ptr, -1);
    else if (!acc) begin
      acc = 1'b1; cnt = 0;
      wl = fixed_wait >= 0 ? fixed_wait : int'($urandom_range(wait_max, 0));
    end else if (m_pready) begin
      ptr = (own + 1) % N; own = pick(s_psel, ptr, own); acc = 1'b0;
    end else if (cnt == T - 1) begin
      own = -1; acc = 1'b0;
    end else cnt++;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++)
      if (last_done[i]) begin
        s_psel[i] = 1'b0; s_pen[i] = 1'b0;
      end else if (s_psel[i]) s_pen[i] = 1'b1;
      else if (int'($urandom_range(99, 0)) < req_pct) issue(i, $urandom());
    if (own >= 0 && acc) begin
      m_pready = !stuck && wl == 0;
      if (wl > 0) wl--;
    end else m_pready = 1'($urandom_range(1, 0));
    m_resp.prdata = fix_data >= 0 ? 32'(fix_data) : $urandom();
    m_resp.pslverr = 1'($urandom_range(1, 0));
  endtask

  task automatic compare();
    bit busy, tmo_e, done_e;
    resp_t [N-1:0] er;
    logic [N-1:0] ep;
    req_t eq;
    busy = own >= 0;
    tmo_e = rst_n && busy && acc && !m_pready && cnt == T - 1;
    done_e = rst_n && busy && acc && (m_pready || tmo_e);
    er = '0; ep = '0; eq = '0;
    if (busy) eq = s_req[own];
    if (done_e) begin
      ep[own] = 1'b1;
      if (m_pready) er[own] = m_resp;
    end
    check("m_psel", m_psel, busy);
    check("m_penable", m_pen, busy && acc);
    check("grant", grant, busy ? own : 0);
    check("m_req", m_req, eq);
    check("s_pready", s_pready, ep);
    check("s_resp", s_resp, er);
    check("timeout", tmo, tmo_e);
    last_done = ep;
    pen_cnt += int'(m_pen);
    if (done_e) begin
      g_q.push_back(own); c_q.push_back(cyc); t_q.push_back(int'(tmo_e));
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk); #1;
      cyc++;
      advance();
      drive();
      @(negedge clk);
      compare();
    end
  endtask

  task automatic check_grants(input string tag, input int exp[5], input int n);
    check({tag, "_count"}, g_q.size() >= n, 1'b1);
    for (int k = 0; k < n && k < g_q.size(); k++) check($sformatf("%s_%0d", tag, k), g_q[k], exp[k]);
    g_q.delete(); c_q.delete(); t_q.delete();
  endtask

  initial begin
    step(3);
    check("rst_psel", m_psel, 1'b0);
    check("rst_grant", grant, 2'd0);
    check("rst_pready", s_pready, 4'b0);
    rst_n = 1'b1;
    step(2);
    // single transfer with zero wait states
    fixed_wait = 0; fix_data = 'hDEAD;
    g_q.delete(); c_q.delete(); t_q.delete();
    c0 = cyc;
    issue(2, 32'h40);
    step(1);
    check("t1_setup_psel", m_psel, 1'b1);
    check("t1_setup_pen", m_pen, 1'b0);
    check("t1_grant", grant, 2'd2);
    check("t1_addr", m_req.paddr, 32'h40);
    step(1);
    check("t1_pen", m_pen, 1'b1);
    check("t1_pready", s_pready, 4'b0100);
    check("t1_prdata", s_resp[2].prdata, 32'hDEAD);
    check("t1_cycle", c_q.size() > 0 ? c_q[0] : -1, c0 + 2);
    step(2);
    check_grants("t1", '{2, 0, 0, 0, 0}, 1);
    fix_data = -1;
    // pointer left at 3: 0 and 3 together must serve 3 first
    issue(0, $urandom()); issue(3, $urandom());
    step(6);
    check_grants("ptr3", '{3, 0, 0, 0, 0}, 2);
    issue(3, $urandom());
    step(4);
    check_grants("t6a", '{3, 0, 0, 0, 0}, 1);
    issue(0, $urandom()); issue(3, $urandom());
    step(6);
    check_grants("t6", '{0, 3, 0, 0, 0}, 2);
    // full contention, back-to-back
    req_pct = 100;
    step(10);
    req_pct = 0;
    step(12);
    for (int k = 0; k < 4 && k + 1 < c_q.size(); k++) check($sformatf("t2_gap_%0d", k), c_q[k + 1] - c_q[k], 2);
    check_grants("t2", '{0, 1, 2, 3, 0}, 5);
    step(2);
    // wait states
    fixed_wait = 3; pen_cnt = 0; c0 = cyc;
    issue(1, $urandom());
    step(7);
    check("t3_pen_cycles", pen_cnt, 4);
    check("t3_cycle", c_q.size() > 0 ? c_q[0] : -1, c0 + 5);
    check_grants("t3", '{1, 0, 0, 0, 0}, 1);
    // timeout on a stuck subordinate
    fixed_wait = 0; stuck = 1'b1; c0 = cyc;
    issue(2, $urandom());
    step(9);
    check("t4_timeout", tmo, 1'b1);
    check("t4_pready", s_pready, 4'b0100);
    check("t4_resp", s_resp, '0);
    step(1);
    check("t4_psel_after", m_psel, 1'b0);
    check("t4_flag", t_q.size() > 0 ? t_q[0] : -1, 1);
    check_grants("t4", '{2, 0, 0, 0, 0}, 1);
    stuck = 1'b0;
    step(1);
    issue(2, $urandom());
    step(4);
    check("t4_fresh_flag", t_q.size() > 0 ? t_q[0] : -1, 0);
    check_grants("t4_fresh", '{2, 0, 0, 0, 0}, 1);
    // reset in the middle of ACCESS
    fixed_wait = 5;
    issue(1, $urandom());
    step(2);
    check("t5_in_access", m_pen, 1'b1);
    rst_n = 1'b0;
    step(1);
    check("t5_psel_after_rst", m_psel, 1'b0);
    check("t5_no_pready", s_pready, 4'b0);
    check("t5_no_done", g_q.size(), 0);
    rst_n = 1'b1; fixed_wait = 0;
    issue(3, $urandom());
    step(6);
    check_grants("t5", '{1, 3, 0, 0, 0}, 2);
    // random traffic
    fixed_wait = -1; wait_max = 3; req_pct = 30;
    step(2000);
    req_pct = 0;
    step(40);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
